// File: rtl/hlsm_avg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : hlsm_avg_sequencer_if
// Description : Start/Done handshake and data bundle for hlsm_avg_sequencer.
//               master : launches operations (Start, samples, num) and
//                        observes Busy, Done, avg, div_by_zero.
//               slave  : the sequencer side of the same signals.
//   Start        launch request, sampled only while the sequencer is idle
//   samples      NUM_IN packed signed samples, sample i = [i*W +: W]
//   num          signed divisor
//   Busy         operation in progress
//   Done         one-cycle completion pulse
//   avg          signed result, held between operations
//   div_by_zero  set with Done when the divisor was zero
// Revision    : 1.0 - initial release
// ============================================================================
interface hlsm_avg_sequencer_if #(
  parameter int W      = 8,
  parameter int NUM_IN = 8
);
  logic                  Start;
  logic [NUM_IN*W-1:0]   samples;
  logic [W-1:0]          num;
  logic                  Busy;
  logic                  Done;
  logic [W-1:0]          avg;
  logic                  div_by_zero;

  modport master (
    output Start, samples, num,
    input  Busy, Done, avg, div_by_zero
  );

  modport slave (
    input  Start, samples, num,
    output Busy, Done, avg, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/hlsm_avg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hlsm_avg_sequencer
// Description : Sequenced signed average: sums NUM_IN captured samples with a
//               single shared adder (one per cycle), then divides the sum by a
//               captured signed divisor with a restoring divider (one quotient
//               bit per cycle). Quotient truncates toward zero; the low W bits
//               are returned. Fixed latency of NUM_IN+ACC_W+1 edges.
// Ports       : Clk  - rising-edge clock
//               Rst  - synchronous active-high reset
//               bus  - hlsm_avg_sequencer_if.slave (Start, samples, num in;
//                      Busy, Done, avg, div_by_zero out)
// Revision    : 1.0 - initial release
// ============================================================================
module hlsm_avg_sequencer #(
  parameter int W      = 8,
  parameter int NUM_IN = 8,
  parameter int ACC_W  = 16
) (
  input  wire logic               Clk,
  input  wire logic               Rst,
  hlsm_avg_sequencer_if.slave     bus
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_IN - 1);
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(ACC_W);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DIV   = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_IN*W-1:0]   smp_q, smp_d;
  logic [W-1:0]          num_q, num_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ACC_W-1:0]      rem_q, rem_d;
  logic [ACC_W-1:0]      quo_q, quo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [W-1:0]          avg_q, avg_d;
  logic                  dbz_q, dbz_d;

  // Unsigned magnitude of a two's-complement value. The result is read as
  // unsigned, so the most negative input maps to 2^(ACC_W-1) exactly, i.e.
  // the same value an ACC_W+1-bit signed negation would give.
  function automatic logic [ACC_W-1:0] mag(input logic [ACC_W-1:0] x);
    return x[ACC_W-1] ? (~x + 1'b1) : x;
  endfunction

  logic [W-1:0] w_smp_arr [NUM_IN];

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
    assign w_smp_arr[gi] = smp_q[gi*W +: W];
  end

  logic [W-1:0]     w_cur;
  logic [ACC_W-1:0] w_cur_ext;
  logic [ACC_W-1:0] w_dvs;
  logic             w_dvs_zero;
  logic             w_neg;
  logic [ACC_W:0]   w_trial;
  logic [ACC_W:0]   w_diff;
  logic             w_ge;

  assign w_cur      = w_smp_arr[idx_q];
  assign w_cur_ext  = {{(ACC_W-W){w_cur[W-1]}}, w_cur};
  assign w_dvs      = mag({{(ACC_W-W){num_q[W-1]}}, num_q});
  assign w_dvs_zero = (num_q == '0);
  assign w_neg      = acc_q[ACC_W-1] ^ num_q[W-1];

  // Restoring step: shift the next dividend bit into the partial remainder
  // and try to subtract the divisor. With a nonzero divisor the trial value
  // stays below 2^ACC_W, so the top bit of the difference is the borrow.
  assign w_trial = {rem_q, quo_q[ACC_W-1]};
  assign w_diff  = w_trial - {1'b0, w_dvs};
  assign w_ge    = ~w_diff[ACC_W];

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    num_d   = num_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    avg_d   = avg_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          smp_d   = bus.samples;
          num_d   = bus.num;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + w_cur_ext;
        idx_d = idx_q + 1'b1;
        if (idx_q == C_IDX_LAST) begin
          // The dividend register is loaded with |sum| as the sum completes.
          quo_d   = mag(acc_d);
          rem_d   = '0;
          cnt_d   = C_CNT_LOAD;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = w_ge ? w_diff[ACC_W-1:0] : w_trial[ACC_W-1:0];
        quo_d = {quo_q[ACC_W-2:0], w_ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == C_CNT_ONE) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (w_dvs_zero) begin
          avg_d = '0;
          dbz_d = 1'b1;
        end else begin
          // Only the low W bits of the signed quotient are kept (wraps).
          avg_d = w_neg ? (~quo_q[W-1:0] + 1'b1) : quo_q[W-1:0];
          dbz_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      smp_q   <= '0;
      num_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      avg_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      num_q   <= num_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      avg_q   <= avg_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.avg         = avg_q;
  assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_hlsm_avg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hlsm_avg_sequencer
// Description : Scoreboard bench for hlsm_avg_sequencer. Each launched
//               operation pushes its expected result (from an integer
//               arithmetic model) and its launch edge; a monitor pops and
//               compares on every Done pulse, including latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hlsm_avg_sequencer;

  localparam int W      = 8;
  localparam int NUM_IN = 8;
  localparam int ACC_W  = 16;
  localparam int LAT    = NUM_IN + ACC_W + 1;

  typedef logic [NUM_IN*W-1:0] smp_t;

  typedef struct {
    logic [W-1:0] avg;
    logic         dbz;
    int           start;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  hlsm_avg_sequencer_if #(.W(W), .NUM_IN(NUM_IN)) bus ();

  hlsm_avg_sequencer #(.W(W), .NUM_IN(NUM_IN), .ACC_W(ACC_W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Reference: signed integer sum, Verilog/C-style truncating division.
  function automatic exp_t model(input smp_t s, input logic [W-1:0] n, input int st);
    exp_t e;
    int   sum = 0;
    int   dv;
    int   q;
    for (int i = 0; i < NUM_IN; i++) sum += int'($signed(s[i*W +: W]));
    dv = int'($signed(n));
    if (dv == 0) begin
      e.avg = '0;
      e.dbz = 1'b1;
    end else begin
      q     = sum / dv;
      e.avg = q[W-1:0];
      e.dbz = 1'b0;
    end
    e.start = st;
    return e;
  endfunction

  function automatic smp_t ramp(input int base, input int step);
    smp_t s;
    int   v;
    for (int i = 0; i < NUM_IN; i++) begin
      v = base + step * i;
      s[i*W +: W] = v[W-1:0];
    end
    return s;
  endfunction

  function automatic smp_t rnd_samples();
    smp_t s;
    for (int i = 0; i < NUM_IN; i++) s[i*W +: W] = W'($urandom);
    return s;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding operation.
  always @(negedge Clk) begin
    if (Rst === 1'b0 && bus.Done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got Done=1, expected no pending operation (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("avg", 32'(bus.avg), 32'(mon_e.avg));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(mon_e.dbz));
        check("latency", 32'(cyc - mon_e.start), 32'(LAT));
      end
    end
  end

  task automatic start_op(input smp_t s, input logic [W-1:0] n);
    @(negedge Clk);
    bus.Start   = 1'b1;
    bus.samples = s;
    bus.num     = n;
    sb.push_back(model(s, n, cyc + 1));
    @(negedge Clk);
    bus.Start   = 1'b0;
    bus.samples = rnd_samples();
    bus.num     = W'($urandom);
    check("busy_after_start", 32'(bus.Busy), 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 4 * LAT) begin
      @(negedge Clk);
      k++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input smp_t s, input logic [W-1:0] n);
    start_op(s, n);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    smp_t       s;
    logic [W-1:0] n;

    Rst         = 1'b1;
    bus.Start   = 1'b0;
    bus.samples = '0;
    bus.num     = '0;
    repeat (3) @(negedge Clk);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_avg", 32'(bus.avg), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    Rst = 1'b0;

    run_op(ramp(10, 10), 8'd8);          // 360/8   = 45
    run_op(ramp(-3, 0), 8'd5);           // -24/5   = -4
    run_op(ramp(10, 10), -8'sd7);        // 360/-7  = -51
    run_op(ramp(127, 0), 8'd1);          // 1016    -> 0xF8
    run_op(ramp(-128, 0), -8'sd128);     // -1024/-128 = 8
    run_op(ramp(1, 1), 8'd0);            // divide by zero
    run_op(ramp(2, 0), 8'd2);            // 16/2 = 8, flag clears

    // Start held high: inputs churn during the operation, the second launch
    // lands on the Done cycle.
    @(negedge Clk);
    s = rnd_samples();
    n = W'($urandom_range(1, 255));
    bus.Start   = 1'b1;
    bus.samples = s;
    bus.num     = n;
    sb.push_back(model(s, n, cyc + 1));
    for (int k = 0; k < LAT; k++) begin
      @(negedge Clk);
      bus.samples = rnd_samples();
      bus.num     = W'($urandom);
    end
    @(negedge Clk);
    s = rnd_samples();
    n = W'($urandom_range(1, 255));
    bus.samples = s;
    bus.num     = n;
    sb.push_back(model(s, n, cyc + 1));
    @(negedge Clk);
    bus.Start = 1'b0;
    wait_idle();

    // Reset in the middle of the divide phase.
    start_op(ramp(50, 3), 8'd3);
    repeat (15) @(negedge Clk);
    Rst = 1'b1;
    void'(sb.pop_back());
    @(negedge Clk);
    Rst = 1'b0;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_done", 32'(bus.Done), 32'd0);
    check("abort_avg", 32'(bus.avg), 32'd0);
    repeat (2 * LAT) @(negedge Clk);
    run_op(ramp(-20, 7), -8'sd3);

    for (int r = 0; r < 20; r++) begin
      s = rnd_samples();
      n = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(s, n);
    end

    repeat (3) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
